lc3b_mem_adapter: RTL and testbench

- Sits between the LC-3b control/datapath memory port and the physical memory port.
- Converts the CPU's level-held mem_read/mem_write requests into a registered pmem transaction and returns a single-cycle mem_resp.
- Steers byte lanes for LDB/STB using address bit 0 and bounds every transaction with a watchdog timeout.

---
 rtl/lc3b_mem_adapter.sv | 178 +++++++++++++++++
 tb/tb_lc3b_mem_adapter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/lc3b_mem_adapter.sv
// lc3b_mem_adapter: bridges the LC-3b level-held memory request to a
// registered physical memory transaction with byte-lane steering and a
// watchdog timeout. Defining LC3B_MEM_PERF_CNT_EN adds saturating
// read/write/stall/timeout counters.
module lc3b_mem_adapter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_error,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [1:0]  pmem_byte_enable,
  output logic [15:0] pmem_wdata,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
`ifdef LC3B_MEM_PERF_CNT_EN
  ,output logic [CNT_WIDTH-1:0] rd_count
  ,output logic [CNT_WIDTH-1:0] wr_count
  ,output logic [CNT_WIDTH-1:0] stall_count
  ,output logic [7:0]           timeout_count
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, HOLD} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        wr_q, wr_d;
  logic        byte_q, byte_d;
  logic        hi_q, hi_d;
  logic        err_q, err_d;

  logic req, is_byte, timeout;

  assign req     = mem_read | mem_write;
  assign is_byte = (mem_byte_enable == 2'b01);
  assign timeout = (state_q == ACCESS) && !pmem_resp && (cnt_q == TO_LAST);

  // State and transaction registers; async reset discards any transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      hi_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  // Next-state: one request per IDLE visit, HOLD swallows a still-held request
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = ACCESS;
      ACCESS:  if (pmem_resp || timeout) state_d = RESP;
      RESP:    state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture and steer lanes at request, collect read data or abort
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    byte_d  = byte_q;
    hi_d    = hi_q;
    err_d   = err_q;
    if (state_q == IDLE && req) begin
      cnt_d   = '0;
      addr_d  = {mem_address[15:1], 1'b0};
      wr_d    = mem_write;
      byte_d  = is_byte;
      hi_d    = mem_address[0];
      // Masks other than 01 behave as full-word accesses
      be_d    = is_byte ? (mem_address[0] ? 2'b10 : 2'b01) : 2'b11;
      wdata_d = is_byte ? {mem_wdata[7:0], mem_wdata[7:0]} : mem_wdata;
      err_d   = !is_byte && mem_address[0];
    end else if (state_q == ACCESS) begin
      if (pmem_resp) begin
        if (!wr_q)
          rdata_d = byte_q ? {8'h00, (hi_q ? pmem_rdata[15:8] : pmem_rdata[7:0])}
                           : pmem_rdata;
      end else begin
        cnt_d = cnt_q + 16'd1;
        if (timeout) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
    end
  end

  // Outputs decoded from state so reset drops the strobes immediately
  always_comb begin
    pmem_read        = (state_q == ACCESS) && !wr_q;
    pmem_write       = (state_q == ACCESS) && wr_q;
    mem_resp         = (state_q == RESP);
    mem_error        = (state_q == RESP) && err_q;
    pmem_address     = addr_q;
    pmem_byte_enable = be_q;
    pmem_wdata       = wdata_q;
    mem_rdata        = rdata_q;
  end

`ifdef LC3B_MEM_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, stall_cnt_q, stall_cnt_d;
  logic [7:0]           to_cnt_q, to_cnt_d;

  // Saturating event counters
  always_comb begin
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    to_cnt_d    = to_cnt_q;
    if (state_q == RESP && !wr_q && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
    if (state_q == RESP && wr_q && wr_cnt_q != '1)  wr_cnt_d = wr_cnt_q + 1'b1;
    if (state_q == ACCESS && !pmem_resp && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    if (timeout && to_cnt_q != '1) to_cnt_d = to_cnt_q + 8'd1;
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
      to_cnt_q    <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  assign rd_count      = rd_cnt_q;
  assign wr_count      = wr_cnt_q;
  assign stall_count   = stall_cnt_q;
  assign timeout_count = to_cnt_q;
`endif

endmodule

// File: tb/tb_lc3b_mem_adapter.sv
// Directed bench for lc3b_mem_adapter (TIMEOUT_CYCLES = 4).
module tb_lc3b_mem_adapter;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_resp, mem_error;
  logic        pmem_read, pmem_write;
  logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
  logic [1:0]  pmem_byte_enable;
  logic        pmem_resp;

  int checks = 0;
  int errors = 0;

  lc3b_mem_adapter #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .mem_error(mem_error),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_byte_enable(pmem_byte_enable),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  be;
    logic [15:0] addr, wdata, prdata;
    int          waits;
    logic [15:0] e_paddr;
    logic [1:0]  e_pbe;
    logic [15:0] e_pwdata, e_rdata;
    logic        e_err;
    int          e_strobe;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drives one transaction from IDLE (called at posedge+1) back to IDLE
  task automatic run_vec(input int idx, input vec_t v);
    int  strobe_cyc;
    bit  got;
    string s;
    s = $sformatf("v%0d", idx);
    mem_read = v.rd; mem_write = v.wr; mem_byte_enable = v.be;
    mem_address = v.addr; mem_wdata = v.wdata; pmem_rdata = v.prdata; pmem_resp = 1'b0;
    tick();
    chk({s, " pmem_read"}, 32'(pmem_read), 32'(v.rd && !v.wr));
    chk({s, " pmem_write"}, 32'(pmem_write), 32'(v.wr));
    chk({s, " pmem_address"}, 32'(pmem_address), 32'(v.e_paddr));
    chk({s, " pmem_be"}, 32'(pmem_byte_enable), 32'(v.e_pbe));
    if (v.wr) chk({s, " pmem_wdata"}, 32'(pmem_wdata), 32'(v.e_pwdata));
    strobe_cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (pmem_read || pmem_write) strobe_cyc++;
      pmem_resp = (k == v.waits);
      tick();
      pmem_resp = 1'b0;
      if (mem_resp) got = 1'b1;
    end
    chk({s, " resp_seen"}, 32'(got), 32'd1);
    chk({s, " strobe_cycles"}, 32'(strobe_cyc), 32'(v.e_strobe));
    chk({s, " mem_rdata"}, 32'(mem_rdata), 32'(v.e_rdata));
    chk({s, " mem_error"}, 32'(mem_error), 32'(v.e_err));
    chk({s, " strobe_off_in_resp"}, 32'(pmem_read | pmem_write), 32'd0);
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
    chk({s, " hold_no_resp"}, 32'(mem_resp), 32'd0);
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'b11, 16'h1000, 16'h0000, 16'hBEEF, 0,  16'h1000, 2'b11, 16'h0000, 16'hBEEF, 1'b0, 1};
    vecs[1] = '{1'b0, 1'b1, 2'b01, 16'h2001, 16'h12AB, 16'h0000, 3,  16'h2000, 2'b10, 16'hABAB, 16'hBEEF, 1'b0, 4};
    vecs[2] = '{1'b1, 1'b0, 2'b01, 16'h3003, 16'h0000, 16'h7F80, 1,  16'h3002, 2'b10, 16'h0000, 16'h007F, 1'b0, 2};
    vecs[3] = '{1'b1, 1'b0, 2'b01, 16'h3002, 16'h0000, 16'h7F80, 0,  16'h3002, 2'b01, 16'h0000, 16'h0080, 1'b0, 1};
    vecs[4] = '{1'b0, 1'b1, 2'b11, 16'h4001, 16'h5678, 16'h0000, 2,  16'h4000, 2'b11, 16'h5678, 16'h0080, 1'b1, 3};
    vecs[5] = '{1'b1, 1'b0, 2'b11, 16'h5000, 16'h0000, 16'hFFFF, 99, 16'h5000, 2'b11, 16'h0000, 16'h0000, 1'b1, 4};
    vecs[6] = '{1'b1, 1'b1, 2'b11, 16'h6000, 16'h9ABC, 16'h1111, 0,  16'h6000, 2'b11, 16'h9ABC, 16'h0000, 1'b0, 1};
    vecs[7] = '{1'b1, 1'b0, 2'b10, 16'h7000, 16'h0000, 16'h1234, 0,  16'h7000, 2'b11, 16'h0000, 16'h1234, 1'b0, 1};
    vecs[8] = '{1'b0, 1'b1, 2'b00, 16'h8000, 16'h4321, 16'h0000, 1,  16'h8000, 2'b11, 16'h4321, 16'h1234, 1'b0, 2};

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
    mem_address = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    tick(); tick();
    chk("rst mem_resp", 32'(mem_resp), 32'd0);
    chk("rst mem_error", 32'(mem_error), 32'd0);
    chk("rst mem_rdata", 32'(mem_rdata), 32'd0);
    chk("rst pmem_strobes", 32'({pmem_read, pmem_write}), 32'd0);
    chk("rst pmem_address", 32'(pmem_address), 32'd0);
    chk("rst pmem_be", 32'(pmem_byte_enable), 32'd0);
    chk("rst pmem_wdata", 32'(pmem_wdata), 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Held read through RESP and HOLD: second access only after IDLE re-samples
    begin
      logic [4:0] strb, resp;
      mem_read = 1'b1; mem_write = 1'b0; mem_byte_enable = 2'b11;
      mem_address = 16'hA000; pmem_rdata = 16'h5555;
      tick();
      for (int c = 0; c < 5; c++) begin
        strb[c] = pmem_read;
        resp[c] = mem_resp;
        pmem_resp = (c == 0 || c == 4);
        tick();
        pmem_resp = 1'b0;
      end
      chk("held strobe_pattern", 32'(strb), 32'b10001);
      chk("held resp_pattern", 32'(resp), 32'b00010);
      chk("held second_resp", 32'(mem_resp), 32'd1);
      mem_read = 1'b0;
      tick(); tick();
    end

    // Reset during an ACCESS wait: strobe drops without a clock edge
    begin
      bit any_resp;
      mem_read = 1'b1; mem_byte_enable = 2'b11; mem_address = 16'hB000;
      tick();
      chk("rstmid strobe_before", 32'(pmem_read), 32'd1);
      tick();
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rstmid strobe_async_drop", 32'(pmem_read), 32'd0);
      mem_read = 1'b0;
      any_resp = 1'b0;
      for (int c = 0; c < 3; c++) begin
        tick();
        if (mem_resp) any_resp = 1'b1;
      end
      @(negedge clk); rst = 1'b0;
      tick();
      if (mem_resp) any_resp = 1'b1;
      chk("rstmid no_resp", 32'(any_resp), 32'd0);
      run_vec(9, vecs[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
